// File: rtl/bch_syndrome_lambda.sv
// bch_syndrome_lambda: bit-serial syndrome (S1, S3) accumulator and direct t=2
// error-locator solver for the BCH(15,7) decoder over GF(2^4), p(x) = x^4 + x + 1.
// Frame flow: COLLECT (15 bits) -> CALC (1 cycle) -> HOLD (until out_ready).
// Optional macro BCH_SYNDROME_OUT_EN adds registered syndrome outputs syn1/syn3.
module bch_syndrome_lambda #(
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned DET_UNCORR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  lambda1,
  output logic [3:0]  lambda2,
  output logic [14:0] cw_out,
  output logic        uncorrectable,
  output logic        out_valid,
`ifdef BCH_SYNDROME_OUT_EN
  output logic [3:0]  syn1,
  output logic [3:0]  syn3,
`endif
  input  logic        out_ready
);

  typedef enum logic [1:0] {StCollect, StCalc, StHold} state_e;

  // Multiply by alpha: shift left, fold x^4 back as x + 1.
  function automatic logic [3:0] gf_mul_a(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_mul_a3(input logic [3:0] x);
    return gf_mul_a(gf_mul_a(gf_mul_a(x)));
  endfunction

  // General GF(16) multiply, Horner over the bits of b (MSB first).
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    acc = 4'h0;
    for (int i = 3; i >= 0; i--) begin
      acc = gf_mul_a(acc) ^ (b[i] ? a : 4'h0);
    end
    return acc;
  endfunction

  // inv(x) = x^14 = x^8 * x^4 * x^2 (x^15 = 1 for nonzero x).
  function automatic logic [3:0] gf_inv(input logic [3:0] x);
    logic [3:0] x2, x4, x8;
    x2 = gf_mul(x, x);
    x4 = gf_mul(x2, x2);
    x8 = gf_mul(x4, x4);
    return gf_mul(gf_mul(x8, x4), x2);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  s3_q, s3_d;
  logic [3:0]  p1_q, p1_d;
  logic [3:0]  p3_q, p3_d;
  logic [14:0] cw_acc_q, cw_acc_d;
  logic [14:0] cw_out_q, cw_out_d;
  logic [3:0]  l1_q, l1_d;
  logic [3:0]  l2_q, l2_d;
  logic        unc_q, unc_d;
  logic        ov_q, ov_d;
  logic [3:0]  cw_idx;
  logic [3:0]  l1_c, l2_c;
  logic        unc_c;
`ifdef BCH_SYNDROME_OUT_EN
  logic [3:0]  syn1_q, syn1_d;
  logic [3:0]  syn3_q, syn3_d;
`endif

  assign cw_idx = (MSB_FIRST != 0) ? (4'd14 - cnt_q) : cnt_q;

  // Peterson solution for t=2 from the accumulated syndromes.
  always_comb begin
    l1_c  = 4'h0;
    l2_c  = 4'h0;
    unc_c = 1'b0;
    if (s1_q != 4'h0) begin
      l1_c = s1_q;
      l2_c = gf_mul(s3_q, gf_inv(s1_q)) ^ gf_mul(s1_q, s1_q);
    end else begin
      unc_c = (s3_q != 4'h0) && (DET_UNCORR != 0);
    end
  end

  // Next-state: frame collection, one-cycle solve, hold until consumed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s1_d     = s1_q;
    s3_d     = s3_q;
    p1_d     = p1_q;
    p3_d     = p3_q;
    cw_acc_d = cw_acc_q;
    cw_out_d = cw_out_q;
    l1_d     = l1_q;
    l2_d     = l2_q;
    unc_d    = unc_q;
    ov_d     = ov_q;
`ifdef BCH_SYNDROME_OUT_EN
    syn1_d   = syn1_q;
    syn3_d   = syn3_q;
`endif
    unique case (state_q)
      StCollect: begin
        if (in_valid) begin
          if (MSB_FIRST != 0) begin
            s1_d = gf_mul_a(s1_q) ^ {3'b000, in_bit};
            s3_d = gf_mul_a3(s3_q) ^ {3'b000, in_bit};
          end else begin
            if (in_bit) begin
              s1_d = s1_q ^ p1_q;
              s3_d = s3_q ^ p3_q;
            end
            p1_d = gf_mul_a(p1_q);
            p3_d = gf_mul_a3(p3_q);
          end
          cw_acc_d[cw_idx] = in_bit;
          if (cnt_q == 4'd14) begin
            cnt_d   = 4'd0;
            state_d = StCalc;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StCalc: begin
        l1_d     = l1_c;
        l2_d     = l2_c;
        unc_d    = unc_c;
        cw_out_d = cw_acc_q;
        ov_d     = 1'b1;
`ifdef BCH_SYNDROME_OUT_EN
        syn1_d   = s1_q;
        syn3_d   = s3_q;
`endif
        state_d  = StHold;
      end
      StHold: begin
        // Result outputs keep their values after the handshake; only out_valid drops.
        if (out_ready) begin
          ov_d    = 1'b0;
          s1_d    = 4'h0;
          s3_d    = 4'h0;
          p1_d    = 4'h1;
          p3_d    = 4'h1;
          cnt_d   = 4'd0;
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StCollect;
      cnt_q    <= 4'd0;
      s1_q     <= 4'h0;
      s3_q     <= 4'h0;
      p1_q     <= 4'h1;
      p3_q     <= 4'h1;
      cw_acc_q <= 15'h0;
      cw_out_q <= 15'h0;
      l1_q     <= 4'h0;
      l2_q     <= 4'h0;
      unc_q    <= 1'b0;
      ov_q     <= 1'b0;
`ifdef BCH_SYNDROME_OUT_EN
      syn1_q   <= 4'h0;
      syn3_q   <= 4'h0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s3_q     <= s3_d;
      p1_q     <= p1_d;
      p3_q     <= p3_d;
      cw_acc_q <= cw_acc_d;
      cw_out_q <= cw_out_d;
      l1_q     <= l1_d;
      l2_q     <= l2_d;
      unc_q    <= unc_d;
      ov_q     <= ov_d;
`ifdef BCH_SYNDROME_OUT_EN
      syn1_q   <= syn1_d;
      syn3_q   <= syn3_d;
`endif
    end
  end

  assign in_ready      = (state_q == StCollect);
  assign lambda1       = l1_q;
  assign lambda2       = l2_q;
  assign cw_out        = cw_out_q;
  assign uncorrectable = unc_q;
  assign out_valid     = ov_q;
`ifdef BCH_SYNDROME_OUT_EN
  assign syn1          = syn1_q;
  assign syn3          = syn3_q;
`endif

endmodule

// File: tb/tb_bch_syndrome_lambda.sv
// Bench for bch_syndrome_lambda: two instances (MSB-first and LSB-first) receive the
// same codeword in their own bit order; a table-based GF(16) model fills a scoreboard.
module tb_bch_syndrome_lambda;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic bit_m, bit_l;
  logic rdy_m, rdy_l, ov_m, ov_l, unc_m, unc_l;
  logic [3:0] l1_m, l1_l, l2_m, l2_l;
  logic [14:0] cw_m, cw_l;
`ifdef BCH_SYNDROME_OUT_EN
  logic [3:0] s1_m, s1_l, s3_m, s3_l;
`endif

  always #5 clk = ~clk;

  bch_syndrome_lambda #(.MSB_FIRST(1), .DET_UNCORR(1)) u_dut_m (
    .clk(clk), .rst(rst), .in_bit(bit_m), .in_valid(in_valid), .in_ready(rdy_m),
    .lambda1(l1_m), .lambda2(l2_m), .cw_out(cw_m), .uncorrectable(unc_m),
    .out_valid(ov_m),
`ifdef BCH_SYNDROME_OUT_EN
    .syn1(s1_m), .syn3(s3_m),
`endif
    .out_ready(out_ready)
  );

  bch_syndrome_lambda #(.MSB_FIRST(0), .DET_UNCORR(1)) u_dut_l (
    .clk(clk), .rst(rst), .in_bit(bit_l), .in_valid(in_valid), .in_ready(rdy_l),
    .lambda1(l1_l), .lambda2(l2_l), .cw_out(cw_l), .uncorrectable(unc_l),
    .out_valid(ov_l),
`ifdef BCH_SYNDROME_OUT_EN
    .syn1(s1_l), .syn3(s3_l),
`endif
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [3:0]  s1;
    logic [3:0]  s3;
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic        unc;
    logic [14:0] cw;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_tab [15];
  int log_tab [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return exp_tab[(log_tab[a] + log_tab[b]) % 15];
  endfunction

  function automatic exp_t model(input logic [14:0] r);
    exp_t e;
    e.s1 = 4'h0;
    e.s3 = 4'h0;
    for (int i = 0; i < 15; i++) begin
      if (r[i]) begin
        e.s1 ^= exp_tab[i % 15];
        e.s3 ^= exp_tab[(3 * i) % 15];
      end
    end
    e.cw = r;
    e.unc = 1'b0;
    if (e.s1 != 4'h0) begin
      e.l1 = e.s1;
      e.l2 = (e.s3 == 4'h0 ? 4'h0 : exp_tab[(log_tab[e.s3] - log_tab[e.s1] + 15) % 15])
             ^ m_mul(e.s1, e.s1);
    end else begin
      e.l1 = 4'h0;
      e.l2 = 4'h0;
      e.unc = (e.s3 != 4'h0);
    end
    return e;
  endfunction

  task automatic check_outs(input string tag, input exp_t e);
    check_eq({tag, "_l1_m"}, 32'(l1_m), 32'(e.l1));
    check_eq({tag, "_l2_m"}, 32'(l2_m), 32'(e.l2));
    check_eq({tag, "_cw_m"}, 32'(cw_m), 32'(e.cw));
    check_eq({tag, "_unc_m"}, 32'(unc_m), 32'(e.unc));
    check_eq({tag, "_l1_l"}, 32'(l1_l), 32'(e.l1));
    check_eq({tag, "_l2_l"}, 32'(l2_l), 32'(e.l2));
    check_eq({tag, "_cw_l"}, 32'(cw_l), 32'(e.cw));
    check_eq({tag, "_unc_l"}, 32'(unc_l), 32'(e.unc));
`ifdef BCH_SYNDROME_OUT_EN
    check_eq({tag, "_syn1_m"}, 32'(s1_m), 32'(e.s1));
    check_eq({tag, "_syn3_m"}, 32'(s3_m), 32'(e.s3));
    check_eq({tag, "_syn1_l"}, 32'(s1_l), 32'(e.s1));
    check_eq({tag, "_syn3_l"}, 32'(s3_l), 32'(e.s3));
`endif
  endtask

  // Drive nbits of frame r (both orders); inputs change on negedge, transfer on posedge.
  task automatic drive_bits(input logic [14:0] r, input int nbits, input bit gaps);
    for (int k = 0; k < nbits; k++) begin
      if (gaps && (k == 3 || k == 8)) begin
        in_valid = 1'b0;
        bit_m = 1'b1;
        bit_l = 1'b1;
        repeat (2) @(negedge clk);
      end
      in_valid = 1'b1;
      bit_m = r[14 - k];
      bit_l = r[k];
      if (!(rdy_m && rdy_l)) check_eq("in_ready_collect", 32'({rdy_m, rdy_l}), 32'h3);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [14:0] r, input bit gaps);
    sb_q.push_back(model(r));
    drive_bits(r, 15, gaps);
  endtask

  // Wait for the result, compare with scoreboard, optionally stall, then handshake.
  task automatic take_result(input string tag, input int stall);
    exp_t e;
    int n;
    n = 0;
    while (!(ov_m && ov_l) && n < 6) begin
      check_eq({tag, "_in_ready_busy"}, 32'({rdy_m, rdy_l}), 32'h0);
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_out_valid"}, 32'({ov_m, ov_l}), 32'h3);
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_outs(tag, e);
    for (int c = 0; c < stall; c++) begin
      in_valid = 1'b1;  // must be ignored in HOLD
      bit_m = 1'b1;
      bit_l = 1'b1;
      @(negedge clk);
      check_eq({tag, "_stall_ready"}, 32'({rdy_m, rdy_l}), 32'h0);
      check_eq({tag, "_stall_ov"}, 32'({ov_m, ov_l}), 32'h3);
      check_outs({tag, "_stall"}, e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_ov_drop"}, 32'({ov_m, ov_l}), 32'h0);
    check_eq({tag, "_ready_back"}, 32'({rdy_m, rdy_l}), 32'h3);
    check_outs({tag, "_kept"}, e);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"}, 32'({rdy_m, rdy_l}), 32'h3);
    check_eq({tag, "_out_valid"}, 32'({ov_m, ov_l}), 32'h0);
    check_eq({tag, "_lambda"}, 32'({l1_m, l2_m, l1_l, l2_l}), 32'h0);
    check_eq({tag, "_cw"}, 32'({cw_m, cw_l}), 32'h0);
    check_eq({tag, "_unc"}, 32'({unc_m, unc_l}), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    v = 4'h1;
    for (int i = 0; i < 15; i++) begin
      exp_tab[i] = v;
      log_tab[v] = i;
      v = {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
    end
    log_tab[0] = 0;
    bit_m = 1'b0;
    bit_l = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_state("rst0");
    rst = 1'b1;
    @(negedge clk);

    send_frame(15'h0000, 1'b0); take_result("zero", 0);
    send_frame(15'h0020, 1'b0); take_result("r5", 0);
    send_frame(15'h0009, 1'b0); take_result("r0r3", 0);
    send_frame(15'h0013, 1'b0); take_result("uncorr", 0);
    for (int i = 0; i < 4; i++) begin
      send_frame(15'($urandom_range(0, 32767)), 1'b0);
      take_result("rand", 0);
    end
    send_frame(15'h0009, 1'b1); take_result("stall", 5);
    send_frame(15'h0000, 1'b0); take_result("after_stall", 0);
    send_frame(15'h4100, 1'b0); take_result("pre_rst", 0);

    // Abort a frame after 7 bits with reset; the following frame must be clean.
    drive_bits(15'h7fff, 7, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_mid");
    rst = 1'b1;
    @(negedge clk);
    send_frame(15'h0020, 1'b0); take_result("r5_after_rst", 0);

    // Reset while holding a result.
    send_frame(15'h0009, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("hold_ov", 32'({ov_m, ov_l}), 32'h3);
    void'(sb_q.pop_front());
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_hold");
    rst = 1'b1;
    @(negedge clk);
    send_frame(15'h0000, 1'b0); take_result("zero_after_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
